dm_access_ctrl: RTL and testbench

- Initiator-side controller for the word-addressed, byte-enabled data memory (11-bit word address, 4-bit BE, We, WD, combinational RD).
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Drives the memory port from registers, then returns the load result (byte/half extracted, sign/zero extended) or a store completion over a valid/ready response channel.
- Flags misaligned and out-of-range accesses instead of issuing them.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_load_ext.sv | 39 +++
 rtl/dm_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller.
//   - request size encodings
//   - controller FSM states
//   - byte-enable patterns for each legal size/offset
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } dm_state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

endpackage

// File: rtl/dm_load_ext.sv
// Load data extraction: selects the byte/half lane addressed by the low address bits
// and sign- or zero-extends it to 32 bits.
//   rd_i       memory read word
//   offset_i   byte offset within the word (addr[1:0])
//   size_i     access size (dm_pkg SZ_*)
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   rdata_o    extended result (0 for the illegal size)
module dm_load_ext (
  input  logic [31:0] rd_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] rdata_o
);
  import dm_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rd_i[7:0];
    case (offset_i)
      2'd1:    byte_v = rd_i[15:8];
      2'd2:    byte_v = rd_i[23:16];
      2'd3:    byte_v = rd_i[31:24];
      default: byte_v = rd_i[7:0];
    endcase
    half_v = offset_i[1] ? rd_i[31:16] : rd_i[15:0];

    rdata_o = '0;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      SZ_HALF: rdata_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      SZ_WORD: rdata_o = rd_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator-side controller for the word-addressed, byte-enabled data memory.
// Takes one load/store at a time over req_valid/req_ready, drives the memory port from
// registers for exactly one ACCESS cycle, then returns the result on rsp_valid/rsp_ready.
// Misaligned, illegal-size and out-of-range requests skip the memory and respond with rsp_err.
//   Clk, Reset_n        clock and synchronous active-low reset
//   req_*               request channel (we, size, unsigned, byte address, right-aligned wdata)
//   rsp_*               response channel (extended load data, error flag)
//   A, BE, We, WD, RD   data-memory port (RD is combinational from A)
module dm_access_ctrl #(
  parameter int unsigned MEM_AW = 11,
  parameter int unsigned DW     = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] A,
  output logic [3:0]        BE,
  output logic              We,
  output logic [DW-1:0]     WD,
  input  logic [DW-1:0]     RD
);
  import dm_pkg::*;

  dm_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [MEM_AW-1:0] a_q, a_d;
  logic [3:0]        be_q, be_d;
  logic              mem_we_q, mem_we_d;
  logic [DW-1:0]     wd_q, wd_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [3:0]        req_be;
  logic [31:0]       ext_rdata;

  // Request legality: alignment by size, and nothing set above the memory's byte range.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ((req_addr >> (MEM_AW + 2)) != 32'd0) req_err = 1'b1;
  end

  always_comb begin
    req_be = '0;
    case (req_size)
      SZ_BYTE: begin
        case (req_addr[1:0])
          2'd0:    req_be = BE_B0;
          2'd1:    req_be = BE_B1;
          2'd2:    req_be = BE_B2;
          default: req_be = BE_B3;
        endcase
      end
      SZ_HALF: req_be = req_addr[1] ? BE_H1 : BE_H0;
      SZ_WORD: req_be = BE_W;
      default: req_be = '0;
    endcase
  end

  dm_load_ext u_load_ext (
    .rd_i       (RD),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_o    (ext_rdata)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    a_d      = a_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    // Strobes live for the ACCESS cycle only; A and WD keep their last value.
    be_d     = '0;
    mem_we_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (req_err) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d  = StAccess;
            err_d    = 1'b0;
            a_d      = req_addr[MEM_AW+1:2];
            be_d     = req_be;
            mem_we_d = req_we;
            if (req_we) wd_d = req_wdata;
          end
        end
      end
      StAccess: begin
        rdata_d = we_q ? '0 : ext_rdata;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      off_q    <= 2'd0;
      a_q      <= '0;
      be_q     <= '0;
      mem_we_q <= 1'b0;
      wd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      a_q      <= a_d;
      be_q     <= be_d;
      mem_we_q <= mem_we_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign A         = a_q;
  assign BE        = be_q;
  // A reset sampled on the ACCESS edge must not let the store commit.
  assign We        = mem_we_q & Reset_n;
  assign WD        = wd_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a behavioural byte-lane data memory.
module tb_dm_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [10:0] A;
  logic [3:0]  BE;
  logic        We;
  logic [31:0] WD, RD;

  always #5 Clk = ~Clk;

  dm_access_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .A            (A),
    .BE           (BE),
    .We           (We),
    .WD           (WD),
    .RD           (RD)
  );

  // Memory model: byte data in WD[7:0], half in WD[15:0], routed to the enabled lanes.
  logic [31:0] mem [0:2047];
  logic        mem_init_done = 1'b0;
  logic [31:0] wr_lanes, wr_word;

  assign RD = mem[A];

  always @(posedge Clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem[2]        = 32'h8001_1234;
      mem[3]        = 32'h80FF_7F01;
      mem[2047]     = 32'h1234_5678;
      mem_init_done = 1'b1;
    end else if (We) begin
      case (BE)
        4'b1111:          wr_lanes = WD;
        4'b0011, 4'b1100: wr_lanes = {2{WD[15:0]}};
        default:          wr_lanes = {4{WD[7:0]}};
      endcase
      wr_word = mem[A];
      for (int i = 0; i < 4; i++) if (BE[i]) wr_word[8*i +: 8] = wr_lanes[8*i +: 8];
      mem[A] = wr_word;
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic err, input logic [3:0] be);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rd; v.exp_err = err; v.exp_be = be;
    vecs.push_back(v);
  endtask

  // Scoreboard consumer: one pop per response handshake.
  always @(negedge Clk) begin
    if (mon_en && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %b, want no response",
                 rsp_rdata, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        chk1({mon_e.name, "_err"}, rsp_err, mon_e.err);
      end
    end
  end

  task automatic drain(input string name);
    int cnt = 0;
    while (sb.size() != 0 && cnt < 20) begin
      @(negedge Clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending responses, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cnt = 0;
    exp_t e;
    @(negedge Clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    while (!req_ready && cnt < 20) begin
      @(negedge Clk);
      cnt++;
    end
    if (!req_ready) begin
      chk1({v.name, "_accept_timeout"}, req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge Clk);
    req_valid = 1'b0;
    chk1({v.name, "_we"}, We, v.we & ~v.exp_err);
    chk({v.name, "_be"}, 32'(BE), 32'(v.exp_be));
    chk1({v.name, "_valid_t1"}, rsp_valid, v.exp_err);
    if (!v.exp_err) begin
      chk({v.name, "_a"}, 32'(A), 32'(v.addr[12:2]));
      if (v.we) chk({v.name, "_wd"}, WD, v.wdata);
      @(negedge Clk);
      chk1({v.name, "_valid_t2"}, rsp_valid, 1'b1);
      chk1({v.name, "_we_off"}, We, 1'b0);
      chk({v.name, "_be_off"}, 32'(BE), 32'h0);
    end
    drain(v.name);
  endtask

  initial begin
    exp_t e;
    Reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_a", 32'(A), 32'h0);
    chk("rst_be", 32'(BE), 32'h0);
    chk1("rst_we", We, 1'b0);
    chk("rst_wd", WD, 32'h0);
    Reset_n = 1'b1;
    mon_en  = 1'b1;

    //   name         we    size   uns   addr          wdata         exp_rdata     err   be
    add("st_b5",      1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00AB, 32'h0,        1'b0, 4'b0010);
    add("ld_w4",      1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_AB00, 1'b0, 4'b1111);
    add("ld_bF_s",    1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'h0,        32'hFFFF_FF80, 1'b0, 4'b1000);
    add("ld_bF_u",    1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0,        32'h0000_0080, 1'b0, 4'b1000);
    add("ld_bC_s",    1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0,        32'h0000_0001, 1'b0, 4'b0001);
    add("ld_bE_s",    1'b0, 2'b00, 1'b0, 32'h0000_000E, 32'h0,        32'hFFFF_FFFF, 1'b0, 4'b0100);
    add("ld_bD_s",    1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0,        32'h0000_007F, 1'b0, 4'b0010);
    add("ld_hA_s",    1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,        32'hFFFF_8001, 1'b0, 4'b1100);
    add("ld_h8_u",    1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,        32'h0000_1234, 1'b0, 4'b0011);
    add("st_h3_err",  1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_BEEF, 32'h0,        1'b1, 4'b0000);
    add("ld_oor_err", 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'h0,        1'b1, 4'b0000);
    add("sz11_err",   1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 4'b0000);
    add("ld_w6_err",  1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 4'b0000);
    add("st_h12",     1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_C0DE, 32'h0,        1'b0, 4'b1100);
    add("ld_w10",     1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hC0DE_0000, 1'b0, 4'b1111);
    add("st_w1C",     1'b1, 2'b10, 1'b0, 32'h0000_001C, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111);
    add("ld_b1D_u",   1'b0, 2'b00, 1'b1, 32'h0000_001D, 32'h0,        32'h0000_00BE, 1'b0, 4'b0010);
    add("ld_h1E_s",   1'b0, 2'b01, 1'b0, 32'h0000_001E, 32'h0,        32'hFFFF_DEAD, 1'b0, 4'b1100);
    add("ld_w_top",   1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,        32'h1234_5678, 1'b0, 4'b1111);
    add("st_b_oor",   1'b1, 2'b00, 1'b0, 32'h0001_0000, 32'h0000_0055, 32'h0,        1'b1, 4'b0000);

    foreach (vecs[i]) run_vec(vecs[i]);

    chk("mem1_after_byte_store", mem[1], 32'h0000_AB00);
    chk("mem0_after_err_store", mem[0], 32'h0);
    chk("mem7_after_word_store", mem[7], 32'hDEAD_BEEF);

    // Backpressure: response held 5 cycles, a second request waits behind the handshake.
    @(negedge Clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_000C; req_wdata = 32'h0;
    e.name = "bp_first";  e.rdata = 32'h80FF_7F01; e.err = 1'b0; sb.push_back(e);
    e.name = "bp_second"; e.rdata = 32'h8001_1234; e.err = 1'b0; sb.push_back(e);
    @(negedge Clk);
    req_addr = 32'h0000_0008;
    chk1("bp_access_ready", req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk1("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_rdata", rsp_rdata, 32'h80FF_7F01);
      chk1("bp_hold_ready", req_ready, 1'b0);
      chk1("bp_hold_we", We, 1'b0);
    end
    @(posedge Clk);
    #1 rsp_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk1("bp_after_hs_ready", req_ready, 1'b1);
    chk1("bp_after_hs_valid", rsp_valid, 1'b0);
    @(negedge Clk);
    req_valid = 1'b0;
    chk("bp_second_be", 32'(BE), 32'hF);
    chk("bp_second_a", 32'(A), 32'h2);
    drain("bp");
    repeat (4) @(negedge Clk);

    // Reset during the ACCESS cycle of a store: no write, no response.
    @(negedge Clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h1111_1111;
    @(negedge Clk);
    req_valid = 1'b0;
    chk1("rstmid_access_we", We, 1'b1);
    chk("rstmid_access_be", 32'(BE), 32'hF);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk1("rstmid_we", We, 1'b0);
    chk("rstmid_be", 32'(BE), 32'h0);
    chk1("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk1("rstmid_req_ready", req_ready, 1'b1);
    chk("rstmid_a", 32'(A), 32'h0);
    chk("rstmid_wd", WD, 32'h0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    chk1("rstmid_no_rsp", rsp_valid, 1'b0);
    chk("rstmid_mem8", mem[8], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
